// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with a 2-entry skid buffer, registered id_ready and flush.
// Invalid slots are presented to execute as all-zero NOP bubbles.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [ALUOP_W-1:0]    id_aluop,
    input  logic [ALUSEL_W-1:0]   id_alusel,
    input  logic [XLEN-1:0]       id_s_op1,
    input  logic [XLEN-1:0]       id_s_op2,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_reg_waddr,
    input  logic                  id_reg_we,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [ALUSEL_W-1:0]   ex_alusel,
    output logic [XLEN-1:0]       ex_s_op1,
    output logic [XLEN-1:0]       ex_s_op2,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_reg_waddr,
    output logic                  ex_reg_we
);

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
        logic [XLEN-1:0]       s_op1;
        logic [XLEN-1:0]       s_op2;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] reg_waddr;
        logic                  reg_we;
    } entry_t;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and id_ready is a pure register output.
    entry_t in_entry;
    entry_t m_q, s_q, m_d, s_d;
    logic   m_valid_q, s_valid_q, m_valid_d, s_valid_d;
    logic   id_ready_q;
    logic   in_fire, out_fire, m_free;

    assign in_entry = '{aluop: id_aluop, alusel: id_alusel, s_op1: id_s_op1, s_op2: id_s_op2,
                        pc: id_pc, reg_waddr: id_reg_waddr, reg_we: id_reg_we};

    assign in_fire  = id_valid & id_ready_q;
    assign out_fire = m_valid_q & ex_ready;
    assign m_free   = ~m_valid_q | out_fire;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_d       = '0;
            s_d       = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
                if (in_fire) begin
                    s_d       = in_entry;
                    s_valid_d = 1'b1;
                end
            end else if (in_fire) begin
                m_d       = in_entry;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // M is stalled; the incoming entry parks in the skid slot.
            s_d       = in_entry;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            id_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            id_ready_q <= ~s_valid_d;
        end
    end

    assign id_ready     = id_ready_q;
    assign ex_valid     = m_valid_q;
    // Drained entries keep their payload bits; the valid gate turns them into NOPs.
    assign ex_aluop     = m_valid_q ? m_q.aluop     : '0;
    assign ex_alusel    = m_valid_q ? m_q.alusel    : '0;
    assign ex_s_op1     = m_valid_q ? m_q.s_op1     : '0;
    assign ex_s_op2     = m_valid_q ? m_q.s_op2     : '0;
    assign ex_pc        = m_valid_q ? m_q.pc        : '0;
    assign ex_reg_waddr = m_valid_q ? m_q.reg_waddr : '0;
    assign ex_reg_we    = m_valid_q & m_q.reg_we;

endmodule
